hub75_capture: RTL



---
 rtl/hub75_capture.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hub75_capture.sv
// HUB75 bus capture: oversamples the panel bus, rebuilds rows in ping-pong banks
// and streams pixels out. Define HUB75_CAPTURE_BLANK_CHECK_EN to enable blank_err.
module hub75_capture #(
    parameter int WIDTH       = 64,
    parameter int ADDR_BITS   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [2:0]                 hub_rgb0,
    input  logic [2:0]                 hub_rgb1,
    input  logic [ADDR_BITS-1:0]       hub_addr,
    input  logic                       hub_blank,
    input  logic                       hub_latch,
    input  logic                       hub_sclk,
    output logic                       px_valid,
    input  logic                       px_ready,
    output logic [$clog2(WIDTH)-1:0]   px_x,
    output logic [ADDR_BITS:0]         px_y,
    output logic [2:0]                 px_rgb,
    output logic                       row_done,
    output logic                       len_err,
    output logic                       overrun,
    output logic                       blank_err
);
    localparam int XW = $clog2(WIDTH);
    localparam int IW = XW + 1;
    localparam int SW = 8 + ADDR_BITS;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [SW-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {hub_rgb0, hub_rgb1, hub_addr, hub_latch, hub_sclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [SW-1:0]        s_bus;
    logic [2:0]           s_rgb0, s_rgb1;
    logic [ADDR_BITS-1:0] s_addr;
    logic                 s_latch, s_sclk;

    assign s_bus   = sync_q[SYNC_STAGES-1];
    assign s_rgb0  = s_bus[SW-1 -: 3];
    assign s_rgb1  = s_bus[SW-4 -: 3];
    assign s_addr  = s_bus[ADDR_BITS+1:2];
    assign s_latch = s_bus[1];
    assign s_sclk  = s_bus[0];

    logic                 sclk_d1_q, latch_d1_q;
    logic [IW-1:0]        col_q, col_d, col_sh;
    logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ADDR_BITS-1:0] row_q, row_d, row_sel;
    logic [0:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d, nidx;
    logic [XW-1:0]        px_x_q, px_x_d;
    logic [ADDR_BITS:0]   px_y_q, px_y_d;
    logic [2:0]           px_rgb_q, px_rgb_d;
    logic                 row_done_q, row_done_d;
    logic                 len_err_q, len_err_d;
    logic                 overrun_q, overrun_d;
    logic [5:0]           mem_q [2*WIDTH];
    logic [5:0]           rdat;
    logic                 sclk_rise, commit, shift, accept, last, fin;
    logic                 start, drop, load, rd_bank;

    assign sclk_rise = s_sclk & ~sclk_d1_q;
    assign commit    = s_latch & ~latch_d1_q;
    assign shift     = sclk_rise && (col_q != IW'(WIDTH));
    assign col_sh    = shift ? col_q + IW'(1) : col_q;
    assign accept    = (state_q == EMIT) && px_ready;
    assign last      = idx_q == IW'(2*WIDTH-1);
    assign fin       = accept && last;
    assign start     = commit && ((state_q == IDLE) || fin);
    assign drop      = commit && !start;
    assign load      = start || (accept && !last);
    assign nidx      = start ? '0 : idx_q + IW'(1);
    assign rd_bank   = start ? wr_bank_q : rd_bank_q;
    assign row_sel   = start ? s_addr : row_q;

    // Forward a same-cycle shift into the first read of a freshly committed bank
    always_comb begin
        rdat = mem_q[{rd_bank, nidx[XW-1:0]}];
        if (shift && (wr_bank_q == rd_bank) && (col_q[XW-1:0] == nidx[XW-1:0]))
            rdat = {s_rgb0, s_rgb1};
    end

    always_comb begin
        col_d      = commit ? '0 : col_sh;
        wr_bank_d  = start ? ~wr_bank_q : wr_bank_q;
        rd_bank_d  = rd_bank;
        row_d      = row_sel;
        state_d    = state_q;
        if (start)    state_d = EMIT;
        else if (fin) state_d = IDLE;
        idx_d      = load ? nidx : idx_q;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_rgb_d   = px_rgb_q;
        if (load) begin
            px_x_d   = nidx[XW-1:0];
            px_y_d   = {nidx[XW], row_sel};
            px_rgb_d = nidx[XW] ? rdat[2:0] : rdat[5:3];
        end
        row_done_d = fin;
        len_err_d  = len_err_q | (commit && (col_sh != IW'(WIDTH)));
        overrun_d  = overrun_q | drop;
    end

    always_ff @(posedge clk) begin
        if (shift) mem_q[{wr_bank_q, col_q[XW-1:0]}] <= {s_rgb0, s_rgb1};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_d1_q  <= 1'b0;
            latch_d1_q <= 1'b0;
            col_q      <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            row_q      <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_rgb_q   <= '0;
            row_done_q <= 1'b0;
            len_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sclk_d1_q  <= s_sclk;
            latch_d1_q <= s_latch;
            col_q      <= col_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            row_q      <= row_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_rgb_q   <= px_rgb_d;
            row_done_q <= row_done_d;
            len_err_q  <= len_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign px_valid = state_q == EMIT;
    assign px_x     = px_x_q;
    assign px_y     = px_y_q;
    assign px_rgb   = px_rgb_q;
    assign row_done = row_done_q;
    assign len_err  = len_err_q;
    assign overrun  = overrun_q;

`ifdef HUB75_CAPTURE_BLANK_CHECK_EN
    logic [SYNC_STAGES-1:0] blank_sync_q;
    logic                   blank_err_q, blank_err_d;

    always_comb begin
        blank_err_d = blank_err_q | (commit && !blank_sync_q[SYNC_STAGES-1]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blank_sync_q <= '0;
            blank_err_q  <= 1'b0;
        end else begin
            blank_sync_q <= {blank_sync_q[SYNC_STAGES-2:0], hub_blank};
            blank_err_q  <= blank_err_d;
        end
    end

    assign blank_err = blank_err_q;
`else
    logic unused_blank;
    assign unused_blank = hub_blank;
    assign blank_err    = 1'b0;
`endif
endmodule
